// File: rtl/mdu_seq.sv
// Multiply/divide sequencer owning HI/LO: stalls the PC while an iterative MULT/DIV runs.
// Optional MDU_DIV0_FAST_EN: divide by zero skips the restoring loop and commits on the next cycle.
module mdu_seq #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mduc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             pc_ena,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               sgn_q, sgn_d, div_q, div_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d;

  logic               issue_sgn, neg_a, neg_b;
  logic [WIDTH-1:0]   mag_a, mag_b, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod_mag, prod;
  logic [WIDTH:0]     trial;

  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v, input logic en);
    return (en && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  assign issue_sgn = (mduc == OP_MULT) || (mduc == OP_DIV);

  // Operands are held raw so divide-by-zero can return the original dividend in HI.
  always_comb begin
    neg_a    = sgn_q & a_q[WIDTH-1];
    neg_b    = sgn_q & b_q[WIDTH-1];
    mag_a    = abs_w(a_q, sgn_q);
    mag_b    = abs_w(b_q, sgn_q);
    prod_mag = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
    prod     = (neg_a ^ neg_b) ? -prod_mag : prod_mag;
    trial    = {rem_q, quo_q[WIDTH-1]} - {1'b0, mag_b};
    if (!div_q) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (b_q == '0) begin
      res_hi = a_q;
      res_lo = '1;
    end else begin
      res_hi = cond_neg(rem_q, neg_a);
      res_lo = cond_neg(quo_q, neg_a ^ neg_b);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    div_d   = div_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    pc_ena  = 1'b1;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          case (mduc)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              pc_ena = 1'b0;
              a_d    = a;
              b_d    = b;
              sgn_d  = issue_sgn;
              div_d  = (mduc == OP_DIV) || (mduc == OP_DIVU);
              rem_d  = '0;
              quo_d  = abs_w(a, issue_sgn);
              if (div_d) begin
                state_d = S_DIV;
                cnt_d   = CNT_W'(WIDTH);
`ifdef MDU_DIV0_FAST_EN
                if (b == '0) state_d = S_DONE;
`endif
              end else if (MUL_CYCLES == 1) begin
                state_d = S_DONE;
              end else begin
                state_d = S_MUL;
                cnt_d   = CNT_W'(MUL_CYCLES - 1);
              end
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
        S_MUL: begin
          pc_ena = 1'b0;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_DONE;
        end
        S_DIV: begin
          // Restoring step: keep the trial difference only when it did not borrow.
          pc_ena = 1'b0;
          if (!trial[WIDTH]) rem_d = trial[WIDTH-1:0];
          else               rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
          quo_d  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_DONE;
        end
        S_DONE: begin
          hi_d    = res_hi;
          lo_d    = res_lo;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (!rst) pc_ena = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Datapath registers carry no reset; they are always loaded at issue before use.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    sgn_q <= sgn_d;
    div_q <= div_d;
    rem_q <= rem_d;
    quo_q <= quo_d;
  end

  assign busy = (state_q != S_IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
